// File: rtl/fmap_bram_arbiter.sv
// Round-robin arbiter between NUM_CLIENTS pipeline stages and one dual-port feature-map BRAM
// (port A read, port B write). Define COLLISION_FWD_EN to forward same-cycle same-address writes into reads.
module fmap_bram_arbiter #(
  parameter int unsigned NUM_CLIENTS     = 3,
  parameter int unsigned COORD_BITS      = 8,
  parameter int unsigned OUT_CHANNELS    = 4,
  parameter int unsigned BITS_PER_NEURON = 8,
  parameter int unsigned IMG_WIDTH       = 32,
  parameter int unsigned IMG_HEIGHT      = 32,
  parameter int unsigned READ_LATENCY    = 1,
  localparam int unsigned DATA_W = OUT_CHANNELS * BITS_PER_NEURON,
  localparam int unsigned ADDR_W = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CLIENTS-1:0]               client_en,
  input  logic [NUM_CLIENTS-1:0]               rd_req,
  input  logic [NUM_CLIENTS*COORD_BITS-1:0]    rd_x,
  input  logic [NUM_CLIENTS*COORD_BITS-1:0]    rd_y,
  output logic [NUM_CLIENTS-1:0]               rd_gnt,
  output logic [NUM_CLIENTS-1:0]               rd_valid,
  output logic [DATA_W-1:0]                    rd_data,
  input  logic [NUM_CLIENTS-1:0]               wr_req,
  input  logic [NUM_CLIENTS*COORD_BITS-1:0]    wr_x,
  input  logic [NUM_CLIENTS*COORD_BITS-1:0]    wr_y,
  input  logic [NUM_CLIENTS*DATA_W-1:0]        wr_data,
  input  logic [NUM_CLIENTS*OUT_CHANNELS-1:0]  wr_ch_mask,
  output logic [NUM_CLIENTS-1:0]               wr_gnt,
  output logic                                 bram_en_a,
  output logic [ADDR_W-1:0]                    bram_addr_a,
  input  logic [DATA_W-1:0]                    bram_dout_a,
  output logic [OUT_CHANNELS-1:0]              bram_we_b,
  output logic [ADDR_W-1:0]                    bram_addr_b,
  output logic [DATA_W-1:0]                    bram_din_b,
  output logic                                 oob_err,
  input  logic                                 err_clr
);

  localparam int unsigned ID_W   = $clog2(NUM_CLIENTS);
  localparam int unsigned PROD_W = ADDR_W + COORD_BITS;
  localparam int unsigned DEPTH  = 1 + READ_LATENCY;

  logic [ID_W-1:0]         rd_ptr, wr_ptr, rd_win, wr_win;
  logic                    rd_found, wr_found, rd_take, coll;
  logic [COORD_BITS-1:0]   rd_wx, rd_wy, wr_wx, wr_wy;
  logic                    rd_inr, wr_inr;
  logic [ADDR_W-1:0]       rd_addr, wr_addr;
  logic [DATA_W-1:0]       wr_wdata;
  logic [OUT_CHANNELS-1:0] wr_wmask;

  logic [DEPTH-1:0][NUM_CLIENTS-1:0] p_oh;
  logic [DEPTH-1:0]                  p_oob;
`ifdef COLLISION_FWD_EN
  logic [DEPTH-1:0]                    p_fwd;
  logic [DEPTH-1:0][DATA_W-1:0]        p_wdata;
  logic [DEPTH-1:0][OUT_CHANNELS-1:0]  p_wmask;
`endif

  // First eligible client at or after ptr, searched cyclically; MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_CLIENTS-1:0] elig,
                                            input logic [ID_W-1:0] ptr);
    logic [ID_W:0] res;
    int unsigned   idx;
    res = '0;
    for (int k = int'(NUM_CLIENTS) - 1; k >= 0; k--) begin
      idx = 32'(ptr) + 32'(k);
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (elig[ID_W'(idx)]) res = {1'b1, ID_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] w);
    return (32'(w) == NUM_CLIENTS - 1) ? '0 : w + ID_W'(1);
  endfunction

  always_comb begin
    {rd_found, rd_win} = rr_pick(rd_req & client_en, rd_ptr);
    {wr_found, wr_win} = rr_pick(wr_req & client_en, wr_ptr);
  end

  // Winner payload mux.
  always_comb begin
    rd_wx    = '0;
    rd_wy    = '0;
    wr_wx    = '0;
    wr_wy    = '0;
    wr_wdata = '0;
    wr_wmask = '0;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (rd_win == ID_W'(i)) begin
        rd_wx = rd_x[i*COORD_BITS +: COORD_BITS];
        rd_wy = rd_y[i*COORD_BITS +: COORD_BITS];
      end
      if (wr_win == ID_W'(i)) begin
        wr_wx    = wr_x[i*COORD_BITS +: COORD_BITS];
        wr_wy    = wr_y[i*COORD_BITS +: COORD_BITS];
        wr_wdata = wr_data[i*DATA_W +: DATA_W];
        wr_wmask = wr_ch_mask[i*OUT_CHANNELS +: OUT_CHANNELS];
      end
    end
  end

  // Range check happens on full coordinates before the row-major product is truncated.
  always_comb begin
    rd_inr  = (32'(rd_wx) < IMG_WIDTH) && (32'(rd_wy) < IMG_HEIGHT);
    wr_inr  = (32'(wr_wx) < IMG_WIDTH) && (32'(wr_wy) < IMG_HEIGHT);
    rd_addr = ADDR_W'(PROD_W'(rd_wy) * PROD_W'(IMG_WIDTH) + PROD_W'(rd_wx));
    wr_addr = ADDR_W'(PROD_W'(wr_wy) * PROD_W'(IMG_WIDTH) + PROD_W'(wr_wx));
    coll    = rd_found && wr_found && rd_inr && wr_inr && (rd_addr == wr_addr);
`ifdef COLLISION_FWD_EN
    rd_take = rd_found;
`else
    rd_take = rd_found && !coll;
`endif
    rd_gnt = '0;
    wr_gnt = '0;
    if (rd_take)  rd_gnt[rd_win] = 1'b1;
    if (wr_found) wr_gnt[wr_win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      bram_en_a   <= 1'b0;
      bram_addr_a <= '0;
      bram_we_b   <= '0;
      bram_addr_b <= '0;
      bram_din_b  <= '0;
      oob_err     <= 1'b0;
      p_oh        <= '0;
      p_oob       <= '0;
`ifdef COLLISION_FWD_EN
      p_fwd       <= '0;
      p_wdata     <= '0;
      p_wmask     <= '0;
`endif
    end else begin
      if (rd_take)  rd_ptr <= rr_next(rd_win);
      if (wr_found) wr_ptr <= rr_next(wr_win);
      bram_en_a <= rd_take && rd_inr;
      if (rd_take && rd_inr) bram_addr_a <= rd_addr;
      bram_we_b <= (wr_found && wr_inr) ? wr_wmask : '0;
      if (wr_found && wr_inr) begin
        bram_addr_b <= wr_addr;
        bram_din_b  <= wr_wdata;
      end
      // A new violation outranks a same-cycle clear.
      if ((rd_take && !rd_inr) || (wr_found && !wr_inr)) oob_err <= 1'b1;
      else if (err_clr)                                   oob_err <= 1'b0;
      p_oh  <= {p_oh[DEPTH-2:0], rd_gnt};
      p_oob <= {p_oob[DEPTH-2:0], rd_take && !rd_inr};
`ifdef COLLISION_FWD_EN
      p_fwd   <= {p_fwd[DEPTH-2:0], rd_take && coll};
      p_wdata <= {p_wdata[DEPTH-2:0], wr_wdata};
      p_wmask <= {p_wmask[DEPTH-2:0], wr_wmask};
`endif
    end
  end

  assign rd_valid = p_oh[READ_LATENCY];

  // Return data: BRAM word, write-first merge on a forwarded collision, zero for out-of-range.
  always_comb begin
    rd_data = bram_dout_a;
`ifdef COLLISION_FWD_EN
    for (int c = 0; c < int'(OUT_CHANNELS); c++) begin
      if (p_fwd[READ_LATENCY] && p_wmask[READ_LATENCY][c])
        rd_data[c*BITS_PER_NEURON +: BITS_PER_NEURON] =
          p_wdata[READ_LATENCY][c*BITS_PER_NEURON +: BITS_PER_NEURON];
    end
`endif
    if (p_oob[READ_LATENCY]) rd_data = '0;
  end

endmodule
